// File: rtl/irq_vector_ctrl.sv
// Vectored interrupt controller for the fetch stage.
// Latches requests, applies a per-source enable mask and fixed priority
// (index 0 highest), and keeps a return-PC/level stack so that strictly
// higher-priority sources can pre-empt a running handler.
module irq_vector_ctrl #(
  parameter int                N_IRQ      = 8,
  parameter int                PC_W       = 32,
  parameter int                DEPTH      = 4,
  parameter logic [PC_W-1:0]   VEC_BASE   = 'h10,
  parameter int                VEC_STRIDE = 4,
  parameter logic [N_IRQ-1:0]  MASK_RST   = '1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_IRQ-1:0]            irq,
  input  logic                        ie,
  input  logic                        stall,
  input  logic                        br_stall,
  input  logic [PC_W-1:0]             ret_pc,
  input  logic                        rti,
  input  logic                        mask_we,
  input  logic [N_IRQ-1:0]            mask_wdata,
  output logic                        take,
  output logic [PC_W-1:0]             vector,
  output logic [PC_W-1:0]             epc,
  output logic [N_IRQ-1:0]            active,
  output logic [$clog2(DEPTH+1)-1:0]  depth,
  output logic [N_IRQ-1:0]            pending,
  output logic                        err
);

  localparam int IDX_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;
  localparam int DEP_W = $clog2(DEPTH + 1);

  logic [N_IRQ-1:0] pending_q, pending_d;
  logic [N_IRQ-1:0] mask_q, mask_d;
  logic [DEP_W-1:0] depth_q, depth_d;
  logic             err_q, err_d;

  // Stack is a shift register: entry 0 is always the top of stack.
  logic [PC_W-1:0]  pc_stk_q  [DEPTH];
  logic [IDX_W-1:0] idx_stk_q [DEPTH];
  logic [PC_W-1:0]  above_pc  [DEPTH];
  logic [IDX_W-1:0] above_idx [DEPTH];
  logic [PC_W-1:0]  below_pc  [DEPTH];
  logic [IDX_W-1:0] below_idx [DEPTH];

  logic             cand_vld;
  logic [IDX_W-1:0] sel_idx;
  logic             stk_empty, stk_full, preempt_ok;
  logic             pop, rti_err;
  logic [N_IRQ-1:0] clr;

  // Lowest-index pending and enabled source wins.
  always_comb begin
    cand_vld = 1'b0;
    sel_idx  = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (pending_q[i] && mask_q[i]) begin
        cand_vld = 1'b1;
        sel_idx  = IDX_W'(i);
      end
    end
  end

  assign stk_empty  = (depth_q == '0);
  assign stk_full   = (depth_q == DEP_W'(DEPTH));
  assign preempt_ok = stk_empty || (sel_idx < idx_stk_q[0]);

  assign take = cand_vld & preempt_ok & ie & ~stall & ~br_stall & ~rti & ~stk_full;

  // A stalled rti is not retiring yet, so it neither pops nor flags an error.
  assign pop     = rti & ~stall & ~stk_empty;
  assign rti_err = rti & ~stall & stk_empty;

  assign clr = take ? (N_IRQ'(1) << sel_idx) : '0;

  // Next-state for pending, mask, depth and the sticky error.
  always_comb begin
    pending_d = (pending_q & ~clr) | irq;
    mask_d    = mask_we ? mask_wdata : mask_q;
    depth_d   = depth_q;
    if (take)
      depth_d = depth_q + DEP_W'(1);
    else if (pop)
      depth_d = depth_q - DEP_W'(1);
    err_d     = err_q | rti_err;
  end

  // Neighbour taps for shifting the stack on push (down) and pop (up).
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_nbr
    if (gi == 0) begin : g_first
      assign above_pc[gi]  = ret_pc;
      assign above_idx[gi] = sel_idx;
    end else begin : g_mid
      assign above_pc[gi]  = pc_stk_q[gi-1];
      assign above_idx[gi] = idx_stk_q[gi-1];
    end
    if (gi == DEPTH - 1) begin : g_last
      assign below_pc[gi]  = '0;
      assign below_idx[gi] = '0;
    end else begin : g_inner
      assign below_pc[gi]  = pc_stk_q[gi+1];
      assign below_idx[gi] = idx_stk_q[gi+1];
    end
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q <= '0;
      mask_q    <= MASK_RST;
      depth_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      mask_q    <= mask_d;
      depth_q   <= depth_d;
      err_q     <= err_d;
    end
  end

  // Return stack: push shifts everything down, pop shifts up and zero-fills.
  always_ff @(posedge clk) begin
    for (int k = 0; k < DEPTH; k++) begin
      if (reset) begin
        pc_stk_q[k]  <= '0;
        idx_stk_q[k] <= '0;
      end else if (take) begin
        pc_stk_q[k]  <= above_pc[k];
        idx_stk_q[k] <= above_idx[k];
      end else if (pop) begin
        pc_stk_q[k]  <= below_pc[k];
        idx_stk_q[k] <= below_idx[k];
      end
    end
  end

  assign vector  = VEC_BASE + PC_W'(sel_idx) * PC_W'(VEC_STRIDE);
  assign epc     = stk_empty ? '0 : pc_stk_q[0];
  assign active  = stk_empty ? '0 : (N_IRQ'(1) << idx_stk_q[0]);
  assign depth   = depth_q;
  assign pending = pending_q;
  assign err     = err_q;

endmodule

// File: doc/irq_vector_ctrl.md
# irq_vector_ctrl

Parametrised vectored interrupt controller for the fetch stage. It latches up to N_IRQ interrupt sources and applies a per-source enable mask and fixed priority. It redirects fetch to a per-source vector address and keeps a return-PC/level stack so higher-priority interrupts can pre-empt a running handler. It supersedes the fixed four-source, single-EPC, non-nesting interrupt logic inside fetch; fetch muxes `vector` or `epc` into its PC register.

## Interface

Parameters:
- N_IRQ, 8: number of interrupt sources (1..16); index 0 is the highest priority.
- PC_W, 32: PC width.
- DEPTH, 4: maximum nesting depth of the return stack (1..8).
- VEC_BASE, 32'h00000010: vector address of source 0.
- VEC_STRIDE, 4: address distance between consecutive vectors.
- MASK_RST, all ones: reset value of the enable mask.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- irq  in  N_IRQ  raw requests; a bit high in any cycle sets the matching pending bit.
- ie  in  1  global interrupt enable from software.
- stall  in  1  pipeline stall; no interrupt is taken while high.
- br_stall  in  1  branch-resolution stall; no interrupt is taken while high.
- ret_pc  in  PC_W  PC to resume at, supplied by fetch.
- rti  in  1  return-from-interrupt is retiring this cycle.
- mask_we  in  1  write strobe for the enable mask.
- mask_wdata  in  N_IRQ  new mask value.
- take  out  1  interrupt accepted this cycle; fetch loads `vector`.
- vector  out  PC_W  VEC_BASE + sel_idx*VEC_STRIDE, truncated to PC_W bits.
- epc  out  PC_W  top-of-stack return PC; 0 when the stack is empty.
- active  out  N_IRQ  one-hot source currently in service (top of stack); 0 when idle.
- depth  out  clog2(DEPTH+1)  number of stacked entries.
- pending  out  N_IRQ  latched, not-yet-taken requests.
- err  out  1  sticky; set by rti with an empty stack.

## Operation

- **Pending latch:** `pending[i] <= (pending[i] & ~clr[i]) | irq[i]`.
  - `clr` is the one-hot of the taken source.
  - If a set and a clear hit the same bit in the same cycle, the set wins.
- **Candidate:** the lowest index i with `pending[i] & mask[i]`; `sel_idx` is that index.
- **Preemption:** the candidate may pre-empt only if depth==0 or sel_idx < the top-of-stack index (strictly higher priority). Equal or lower priority waits in pending.
- **take** (combinational) = candidate exists & preemption allowed & ie & ~stall & ~br_stall & ~rti & depth<DEPTH.
- **On take, at the clock edge:**
  - push {ret_pc, sel_idx};
  - depth+1;
  - clear pending[sel_idx].
- **On rti with depth>0, at the clock edge:** pop and depth-1. `epc` shows the popped PC during the rti cycle. After the pop, `active` shows the next lower stack entry.
- **On rti with depth==0:** no pop and depth stays 0; err <= 1.
- **rti and a candidate in the same cycle:** rti wins and take is 0. The candidate is re-evaluated next cycle against the new top.
- **Stack full (depth==DEPTH):** take stays 0 and requests remain pending.
- **mask_we:** mask <= mask_wdata at the edge, effective from the next cycle. A masked source stays pending and becomes eligible when it is unmasked.
- **Masking the source in service** does not disturb the stack.
- **Reset values:**
  - pending=0, mask=MASK_RST, depth=0, err=0;
  - take=0, active=0, epc=0;
  - vector = VEC_BASE + sel_idx*VEC_STRIDE is combinational and undefined-free; with no candidate sel_idx=0, so vector=VEC_BASE.
- **Reset mid-handler:** the stack is discarded and pending is cleared.

## Timing

- irq is sampled at edge T. pending is visible in cycle T+1, and take can be asserted in cycle T+1 (one-cycle latency).
- take, vector and sel_idx are combinational within a cycle. Stack, depth and pending update at the edge that ends the take cycle.
- epc and active are registered stack outputs and never change mid-cycle.
- A stall holds everything except the pending latch, which keeps collecting requests.
- Back-to-back: a higher-priority source may be taken in the cycle immediately after a take.

## Test plan

- **Single request:** irq=8'h04 for one cycle, ie=1, ret_pc=32'h100.
  - take=1 next cycle with vector=32'h18.
  - Then depth=1, active=8'h04, epc=32'h100, pending=0.
  - rti → depth=0, epc=0.
- **Priority and nesting:**
  - While source 2 is active, irq[0] rises: take with vector=32'h10, depth=2, epc=ret_pc.
  - irq[5] while source 0 is active stays pending.
  - After two rti pulses, source 5 is taken.
- **Stalls:** irq[1] while stall=1 for 3 cycles → take=0 throughout, pending[1]=1. take occurs in the first cycle with stall=0 and br_stall=0.
- **Masking:**
  - mask_wdata=8'hFE then irq[0] → no take, pending[0]=1.
  - Unmasking → take on the next cycle.
- **Boundaries:**
  - DEPTH entries pushed → next candidate held and pending.
  - rti with an empty stack → err=1, depth stays 0.
  - rti and a new request in the same cycle → take=0 that cycle, 1 the next.
- **Reset mid-handler:** reset with depth=2 → depth=0, active=0, pending=0, err=0, mask=MASK_RST.
